// File: rtl/sd_io_pkg.sv
// sd_io_pkg: shared definitions for the host sector-IO arbiter.
//   state_t          - arbiter FSM encoding (IDLE, REQ, XFER)
//   ACK_TIMEOUT_DEF  - default clk_sys cycles to wait for the host ack rise
package sd_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam int unsigned ACK_TIMEOUT_DEF = 32'd16777215;

endpackage

// File: rtl/sd_io_arbiter_if.sv
// sd_io_arbiter_if: host-side sector-IO channel.
//   sd_lba      - sector address to host
//   sd_rd/sd_wr - one-sector read/write request to host
//   sd_ack      - host transfer-active level
//   sd_buff_din - buffer read data (drive -> host)
// modport master: the arbiter side; modport slave: the HPS IO side.
interface sd_io_arbiter_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_din;

  modport master (output sd_lba, sd_rd, sd_wr, sd_buff_din, input sd_ack);
  modport slave  (input sd_lba, sd_rd, sd_wr, sd_buff_din, output sd_ack);
endinterface

// File: rtl/sd_rr_pick.sv
// sd_rr_pick: combinational round-robin first-set finder.
//   pend - request vector, one bit per drive
//   rr   - drive index where the scan starts (wraps at NUM_DRV)
//   vld  - any pend bit set
//   idx  - first set bit at or after rr, modulo NUM_DRV
module sd_rr_pick #(
  parameter int NUM_DRV = 2,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_DRV-1:0] pend,
  input  logic [IDX_W-1:0]   rr,
  output logic               vld,
  output logic [IDX_W-1:0]   idx
);

  // Rotate so bit 0 is the drive at rr; the lowest set bit is the winner.
  logic [2*NUM_DRV-1:0] rot;
  logic [IDX_W-1:0]     off;
  logic [IDX_W:0]       sum;

  assign rot = {pend, pend} >> rr;

  always_comb begin
    vld = 1'b0;
    off = '0;
    for (int k = NUM_DRV - 1; k >= 0; k--) begin
      if (rot[k]) begin
        vld = 1'b1;
        off = IDX_W'(k);
      end
    end
  end

  assign sum = {1'b0, rr} + {1'b0, off};
  assign idx = (sum >= (IDX_W+1)'(NUM_DRV)) ? IDX_W'(sum - (IDX_W+1)'(NUM_DRV))
                                            : sum[IDX_W-1:0];

endmodule

// File: rtl/sd_io_arbiter.sv
// sd_io_arbiter: shares one host sector-IO channel between NUM_DRV virtual
// SD drives, one sector request at a time, round-robin.
//   clk_sys, reset   - system clock, synchronous active-high reset
//   drv_lba/rd/wr    - per-drive sector address and request levels
//   drv_ack          - per-drive ack; only the granted drive sees sd_ack
//   drv_buff_din     - per-drive buffer data, muxed onto host.sd_buff_din
//   host             - host channel (sd_io_arbiter_if.master)
//   grant_idx        - current or last granted drive
//   busy             - FSM not in IDLE
//   timeout_err      - one-cycle pulse when a request is abandoned
module sd_io_arbiter
  import sd_io_pkg::*;
#(
  parameter int          NUM_DRV     = 2,
  parameter int          IDX_W       = 2,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [32*NUM_DRV-1:0]  drv_lba,
  input  logic [NUM_DRV-1:0]     drv_rd,
  input  logic [NUM_DRV-1:0]     drv_wr,
  output logic [NUM_DRV-1:0]     drv_ack,
  input  logic [8*NUM_DRV-1:0]   drv_buff_din,
  sd_io_arbiter_if.master        host,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic                   timeout_err
);

  // Per-drive views padded to the full index range so any grant_idx value
  // selects a defined entry.
  localparam int N2 = 1 << IDX_W;

  logic [N2-1:0][31:0] lba_arr;
  logic [N2-1:0][7:0]  din_arr;
  logic [N2-1:0]       rd_arr;

  for (genvar i = 0; i < N2; i++) begin : g_pad
    if (i < NUM_DRV) begin : g_drv
      assign lba_arr[i] = drv_lba[32*i +: 32];
      assign din_arr[i] = drv_buff_din[8*i +: 8];
      assign rd_arr[i]  = drv_rd[i];
    end else begin : g_nil
      assign lba_arr[i] = '0;
      assign din_arr[i] = '0;
      assign rd_arr[i]  = 1'b0;
    end
  end

  state_t             state;
  logic [IDX_W-1:0]   rr;
  logic [NUM_DRV-1:0] done;
  logic [NUM_DRV-1:0] req_any;
  logic [NUM_DRV-1:0] pend;
  logic [NUM_DRV-1:0] done_keep;
  logic [N2-1:0]      gsel;
  logic [IDX_W-1:0]   rr_next;
  logic [31:0]        to_cnt;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;

  // done masks a finished drive until it drops its request; drives release
  // rd/wr some cycles after ack falls and must not be granted twice.
  assign req_any   = drv_rd | drv_wr;
  assign pend      = req_any & ~done;
  assign done_keep = done & req_any;

  assign gsel    = N2'(1) << grant_idx;
  assign rr_next = (grant_idx == IDX_W'(NUM_DRV - 1)) ? '0 : grant_idx + 1'b1;

  sd_rr_pick #(.NUM_DRV(NUM_DRV), .IDX_W(IDX_W)) u_pick (
    .pend (pend),
    .rr   (rr),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  // Ack passes through combinationally so the drive's buffer write-enable
  // follows the host in the same cycle, including the rise seen in REQ.
  assign drv_ack          = (state != ST_IDLE && host.sd_ack) ? gsel[NUM_DRV-1:0] : '0;
  assign host.sd_buff_din = din_arr[grant_idx];
  assign busy             = (state != ST_IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr          <= '0;
      done        <= '0;
      grant_idx   <= '0;
      host.sd_lba <= '0;
      host.sd_rd  <= 1'b0;
      host.sd_wr  <= 1'b0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
    end else begin
      timeout_err <= 1'b0;
      done        <= done_keep;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_idx   <= pick_idx;
            host.sd_lba <= lba_arr[pick_idx];
            host.sd_rd  <= rd_arr[pick_idx];   // rd wins when both are high
            host.sd_wr  <= ~rd_arr[pick_idx];
            to_cnt      <= '0;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (host.sd_ack) begin
            host.sd_rd <= 1'b0;
            host.sd_wr <= 1'b0;
            state      <= ST_XFER;
          end else if (ACK_TIMEOUT != 0 && to_cnt == ACK_TIMEOUT - 1) begin
            host.sd_rd  <= 1'b0;
            host.sd_wr  <= 1'b0;
            done        <= done_keep | gsel[NUM_DRV-1:0];
            timeout_err <= 1'b1;
            rr          <= rr_next;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (!host.sd_ack) begin
            done  <= done_keep | gsel[NUM_DRV-1:0];
            rr    <= rr_next;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
